// File: rtl/memory_unit_param.sv
// Parametrised symbol/count memory for the Huffman coder: read, write, saturating
// increment with same-address forwarding, and a hardware clear sweep.
module memory_unit_param #(
  parameter int                DATA_W    = 12,
  parameter int                ADDR_W    = 6,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              req,
  input  logic [1:0]        modeselect,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  output logic              ready,
  output logic              busy,
  output logic [DATA_W-1:0] data_out,
  output logic              out_valid,
  output logic              saturated
);

  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;
  typedef enum logic [1:0] {
    MODE_RD  = 2'b00,
    MODE_WR  = 2'b01,
    MODE_INC = 2'b10,
    MODE_NOP = 2'b11
  } mode_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   ptr;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                run, kill, accept, acc_wr, acc_rd;
  logic                vld_p1, inc_p1;
  logic [ADDR_W-1:0]   addr_p1;
  logic [DATA_W-1:0]   rd_p1;
  logic                wb_en, fwd;
  logic [DATA_W-1:0]   wb_val;

  // Counts stick at all-ones instead of wrapping to zero.
  function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
    return (&v) ? v : v + DATA_W'(1);
  endfunction

  assign run    = (state == ST_RUN);
  assign kill   = run & clear;
  assign accept = run & req & ~clear;
  assign acc_wr = accept & (modeselect == MODE_WR);
  assign acc_rd = accept & ((modeselect == MODE_RD) | (modeselect == MODE_INC));

  assign wb_en  = vld_p1 & inc_p1;
  assign wb_val = sat_inc(rd_p1);
  assign fwd    = wb_en & (addr_p1 == addr);

  assign busy   = ~run;
  assign ready  = run;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_CLEAR: if (&ptr) state_nxt = ST_RUN;
      ST_RUN:   if (clear) state_nxt = ST_CLEAR;
      default:  state_nxt = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_CLEAR) ptr <= ptr + ADDR_W'(1);
      else if (clear)        ptr <= '0;
    end
  end

  // A write request accepted on the same edge as an increment write-back wins.
  always_ff @(posedge clock) begin
    if (!run) begin
      mem[ptr] <= CLEAR_VAL;
    end else begin
      if (wb_en)  mem[addr_p1] <= wb_val;
      if (acc_wr) mem[addr]    <= data;
    end
  end

  // Stage 0 -> 1: array read, bypassing a same-address increment still being written back
  always_ff @(posedge clock) begin
    if (acc_rd) begin
      rd_p1   <= fwd ? wb_val : mem[addr];
      addr_p1 <= addr;
      inc_p1  <= (modeselect == MODE_INC);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) vld_p1 <= 1'b0;
    else       vld_p1 <= acc_rd;
  end

  // Stage 1 -> 2: result register; a clear drops whatever sits in stage 1
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_out  <= '0;
      out_valid <= 1'b0;
      saturated <= 1'b0;
    end else begin
      out_valid <= vld_p1 & ~kill;
      saturated <= vld_p1 & ~kill & inc_p1 & (&rd_p1);
      if (vld_p1 && !kill) data_out <= inc_p1 ? wb_val : rd_p1;
    end
  end

endmodule
